// File: rtl/mat_mem_loader_pkg.sv
// Shared sizing table, FSM encoding and word-count helpers for the matrix loader and multiplier.
// Also provides the `CLOG2 macro used for address and counter widths.
`ifndef MAT_MEM_LOADER_PKG_SV
`define MAT_MEM_LOADER_PKG_SV

`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

package mat_mem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } loader_state_e;

    function automatic int unsigned set_row_bytes(input string set);
        if (set == "L1") return 104;
        if (set == "L3") return 159;
        if (set == "L5") return 202;
        return 8;
    endfunction

    function automatic int unsigned set_col_bytes(input string set);
        if (set == "L1") return 126;
        if (set == "L3") return 193;
        if (set == "L5") return 278;
        return 8;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Padded rows each start on a fresh word; otherwise the stream packs densely.
    function automatic int unsigned mat_words(input int unsigned row_bytes,
                                              input int unsigned col_bytes,
                                              input int unsigned n_gf,
                                              input bit          row_pad);
        if (row_pad) return col_bytes * ceil_div(row_bytes, n_gf);
        return ceil_div(row_bytes * col_bytes, n_gf);
    endfunction

endpackage

`endif

// File: rtl/mat_mem_loader_byte_packer.sv
// Packs a byte stream MSB-first into N_GF-byte words; a word closes when full or on last.
// Unfilled lanes of a short word read as zero.
module mat_mem_loader_byte_packer #(
    parameter int unsigned N_GF      = 8,
    parameter int unsigned PROC_SIZE = N_GF * 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 last,
    input  logic [7:0]           data,
    output logic [PROC_SIZE-1:0] word,
    output logic                 word_valid
);

    localparam int unsigned LW = `CLOG2(N_GF);

    logic [LW-1:0]        lane_q;
    logic [PROC_SIZE-1:0] shreg_q;
    logic [PROC_SIZE-1:0] shifted;
    logic [PROC_SIZE-1:0] aligned;
    logic [PROC_SIZE-1:0] word_q;
    logic                 word_valid_q;
    logic                 lane_full;

    assign lane_full = (lane_q == LW'(N_GF - 1));

    // Newest byte sits in the low lane; left-align so lane 0 ends up in the MSBs.
    always_comb begin
        shifted = (shreg_q << 8) | PROC_SIZE'(data);
        aligned = shifted << (8 * (N_GF - 1 - int'(lane_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q       <= '0;
            shreg_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (push) begin
                if (last || lane_full) begin
                    lane_q       <= '0;
                    shreg_q      <= '0;
                    word_q       <= aligned;
                    word_valid_q <= 1'b1;
                end else begin
                    lane_q  <= lane_q + LW'(1);
                    shreg_q <= shifted;
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/mat_mem_loader.sv
// Writer side of the matrix RAM: streams H' bytes in, writes packed words from address 0.
// Define MAT_LOADER_ROW_PAD_EN to start every matrix row on a fresh word.
module mat_mem_loader
    import mat_mem_loader_pkg::*;
#(
    parameter string       PARAMETER_SET      = "L5",
    parameter int unsigned MAT_ROW_SIZE_BYTES = set_row_bytes(PARAMETER_SET),
    parameter int unsigned MAT_COL_SIZE_BYTES = set_col_bytes(PARAMETER_SET),
    parameter int unsigned N_GF               = 8,
    parameter int unsigned PROC_SIZE          = N_GF * 8,
`ifdef MAT_LOADER_ROW_PAD_EN
    localparam bit          ROW_PAD     = 1'b1,
`else
    localparam bit          ROW_PAD     = 1'b0,
`endif
    localparam int unsigned TOTAL_BYTES = MAT_ROW_SIZE_BYTES * MAT_COL_SIZE_BYTES,
    localparam int unsigned WPR         = ceil_div(MAT_ROW_SIZE_BYTES, N_GF),
    localparam int unsigned WORDS       = mat_words(MAT_ROW_SIZE_BYTES, MAT_COL_SIZE_BYTES,
                                                    N_GF, ROW_PAD),
    localparam int unsigned AW          = `CLOG2(WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    output logic [AW-1:0]        o_mem_addr,
    output logic [PROC_SIZE-1:0] o_mem_data,
    output logic                 o_mem_wen,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned   CW        = `CLOG2(TOTAL_BYTES + 1);
    localparam logic [CW-1:0] TotalCnt  = CW'(TOTAL_BYTES);
    localparam logic [AW-1:0] LastAddr  = AW'(WORDS - 1);

    loader_state_e        state_q, state_d;
    logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 start_load;
    logic                 xfer;
    logic                 last_byte;
    logic                 close_word;
    logic [PROC_SIZE-1:0] word;
    logic                 word_valid;

    assign start_load   = (state_q == StIdle) && i_start;
    assign o_byte_ready = (state_q == StLoad) && (byte_cnt_q != TotalCnt);
    assign xfer         = i_byte_valid && o_byte_ready;
    assign last_byte    = (byte_cnt_q == TotalCnt - CW'(1));

`ifdef MAT_LOADER_ROW_PAD_EN
    localparam int unsigned RW = `CLOG2(MAT_ROW_SIZE_BYTES);

    logic [RW-1:0] row_byte_q;
    logic          row_end;

    assign row_end    = (row_byte_q == RW'(MAT_ROW_SIZE_BYTES - 1));
    assign close_word = last_byte || row_end;

    always_ff @(posedge i_clk) begin
        if (i_rst || start_load) begin
            row_byte_q <= '0;
        end else if (xfer) begin
            row_byte_q <= row_end ? '0 : row_byte_q + RW'(1);
        end
    end
`else
    assign close_word = last_byte;
`endif

    mat_mem_loader_byte_packer #(
        .N_GF      (N_GF),
        .PROC_SIZE (PROC_SIZE)
    ) u_byte_packer (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (xfer),
        .last       (close_word),
        .data       (i_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StLoad;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                end
            end
            StLoad: begin
                if (xfer) byte_cnt_d = byte_cnt_q + CW'(1);
                if (word_valid) begin
                    // Saturate so the address stays inside the RAM after the final word.
                    if (addr_q != LastAddr) addr_d = addr_q + AW'(1);
                    if (byte_cnt_q == TotalCnt) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_data = word;
    assign o_mem_wen  = word_valid;
    assign o_busy     = (state_q != StIdle);
    assign o_done     = (state_q == StDone);

endmodule

// File: tb/tb_mat_mem_loader.sv
// Directed bench for mat_mem_loader: 8x8 small set plus a 10x2 / N_GF=4 instance.
// Expectations for the second instance follow MAT_LOADER_ROW_PAD_EN.
module tb_mat_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        start_a, valid_a, ready_a, wen_a, busy_a, done_a;
    logic [7:0]  byte_a;
    logic [2:0]  addr_a;
    logic [63:0] data_a;
    logic        start_b, valid_b, ready_b, wen_b, busy_b, done_b;
    logic [7:0]  byte_b;
    logic [2:0]  addr_b;
    logic [31:0] data_b;

    mat_mem_loader #(
        .PARAMETER_SET ("SMALL")
    ) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start_a),
        .i_byte       (byte_a),
        .i_byte_valid (valid_a),
        .o_byte_ready (ready_a),
        .o_mem_addr   (addr_a),
        .o_mem_data   (data_a),
        .o_mem_wen    (wen_a),
        .o_busy       (busy_a),
        .o_done       (done_a)
    );

    mat_mem_loader #(
        .PARAMETER_SET      ("SMALL"),
        .MAT_ROW_SIZE_BYTES (10),
        .MAT_COL_SIZE_BYTES (2),
        .N_GF               (4)
    ) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start_b),
        .i_byte       (byte_b),
        .i_byte_valid (valid_b),
        .o_byte_ready (ready_b),
        .o_mem_addr   (addr_b),
        .o_mem_data   (data_b),
        .o_mem_wen    (wen_b),
        .o_busy       (busy_b),
        .o_done       (done_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // RAM images and event counters captured from the write ports.
    logic [63:0] ram_a [8];
    logic [31:0] ram_b [8];
    int wr_a, wr_b, done_cnt_a, done_cnt_b, done_cyc_a, max_a, first_a, last_xfer_a;

    always @(negedge clk) begin
        if (wen_a) begin
            ram_a[addr_a] = data_a;
            wr_a++;
            if (int'(addr_a) > max_a) max_a = int'(addr_a);
            if (first_a < 0) first_a = int'(addr_a);
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (wen_b) begin
            ram_b[addr_b] = data_b;
            wr_b++;
        end
        if (done_b) done_cnt_b++;
    end

    function automatic logic [63:0] exp_a(input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[63-8*j -: 8] = 8'(8 * k + j);
        return w;
    endfunction

    task automatic clear_a();
        for (int k = 0; k < 8; k++) ram_a[k] = 64'hDEAD_BEEF_DEAD_BEEF;
        wr_a = 0; done_cnt_a = 0; done_cyc_a = -1; max_a = 0; first_a = -1; last_xfer_a = -1;
    endtask

    // Streams bytes 0..63 into dut_a; optional gaps, start re-pulse, abort and overrun.
    task automatic load_a(input int gap_pct, input int repulse_at, input int abort_after,
                          input int extra, input string tag);
        int  i, guard, ex_ready;
        bit  pulsed;
        i = 0; guard = 0; ex_ready = 0; pulsed = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        while (i < 64 && guard < 2000) begin
            valid_a = ($urandom_range(99) >= gap_pct);
            byte_a  = 8'(i);
            start_a = (repulse_at >= 0) && (i == repulse_at) && !pulsed;
            if (start_a) pulsed = 1;
            if (valid_a && ready_a) begin
                last_xfer_a = cyc;
                i++;
            end
            @(negedge clk);
            guard++;
            if (i == abort_after) break;
        end
        start_a = 1'b0;
        valid_a = 1'b0;
        if (abort_after >= 0) begin
            check({tag, "_xfers"}, 64'(i), 64'(abort_after));
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end
        check({tag, "_xfers"}, 64'(i), 64'd64);
        for (int e = 0; e < extra; e++) begin
            valid_a = 1'b1;
            byte_a  = 8'hEE;
            if (ready_a) ex_ready++;
            @(negedge clk);
        end
        valid_a = 1'b0;
        if (extra > 0) check({tag, "_ready_extra"}, 64'(ex_ready), 64'd0);
        guard = 0;
        while (done_cnt_a == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_image_a(input string tag);
        check({tag, "_writes"}, 64'(wr_a), 64'd8);
        check({tag, "_done_cnt"}, 64'(done_cnt_a), 64'd1);
        check({tag, "_first_addr"}, 64'(first_a), 64'd0);
        check({tag, "_max_addr"}, 64'(max_a), 64'd7);
        for (int k = 0; k < 8; k++) check({tag, "_word"}, ram_a[k], exp_a(k));
        check({tag, "_busy_after"}, 64'(busy_a), 64'd0);
    endtask

    task automatic load_b();
        int i, guard;
        i = 0; guard = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        while (i < 20 && guard < 200) begin
            valid_b = 1'b1;
            byte_b  = 8'(i + 1);
            if (ready_b) i++;
            @(negedge clk);
            guard++;
        end
        valid_b = 1'b0;
        check("b_xfers", 64'(i), 64'd20);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; valid_a = 1'b0; byte_a = 8'h00;
        start_b = 1'b0; valid_b = 1'b0; byte_b = 8'h00;
        for (int k = 0; k < 8; k++) ram_b[k] = 32'hDEAD_BEEF;
        wr_b = 0; done_cnt_b = 0;
        clear_a();
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_wen",   64'(wen_a),   64'd0);
        check("rst_busy",  64'(busy_a),  64'd0);
        check("rst_done",  64'(done_a),  64'd0);
        check("rst_addr",  64'(addr_a),  64'd0);
        check("rst_data",  data_a,       64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: contiguous stream, valid held high
        clear_a();
        load_a(0, -1, -1, 0, "t1");
        check_image_a("t1");
        check("t1_addr0", ram_a[0], 64'h0001_0203_0405_0607);
        check("t1_done_lat", 64'(done_cyc_a - last_xfer_a), 64'd2);

        // 4: random gaps with start re-pulsed mid-load
        clear_a();
        load_a(50, 20, -1, 0, "t4");
        check_image_a("t4");
        check("t4_done_lat", 64'(done_cyc_a - last_xfer_a), 64'd2);

        // 5: reset after 30 bytes, then a clean reload
        clear_a();
        load_a(0, -1, 30, 0, "t5a");
        check("t5_abort_done", 64'(done_cnt_a), 64'd0);
        check("t5_abort_writes", 64'(wr_a), 64'd3);
        check("t5_abort_busy", 64'(busy_a), 64'd0);
        clear_a();
        load_a(0, -1, -1, 0, "t5");
        check_image_a("t5");

        // 6: valid held past the end of the matrix
        clear_a();
        load_a(0, -1, -1, 10, "t6");
        check_image_a("t6");
        check("t6_done_lat", 64'(done_cyc_a - last_xfer_a), 64'd2);

        // 2/3: 10x2 matrix, N_GF=4, bytes 1..20
        load_b();
        check("b_done_cnt", 64'(done_cnt_b), 64'd1);
        check("b_addr0", 64'(ram_b[0]), 64'h0102_0304);
`ifdef MAT_LOADER_ROW_PAD_EN
        check("t3_writes", 64'(wr_b), 64'd6);
        check("t3_addr2", 64'(ram_b[2]), 64'h090A_0000);
        check("t3_addr3", 64'(ram_b[3]), 64'h0B0C_0D0E);
        check("t3_addr5", 64'(ram_b[5]), 64'h1314_0000);
`else
        check("t2_writes", 64'(wr_b), 64'd5);
        check("t2_addr2", 64'(ram_b[2]), 64'h090A_0B0C);
        check("t2_addr4", 64'(ram_b[4]), 64'h1112_1314);
        check("t2_addr5_untouched", 64'(ram_b[5]), 64'hDEAD_BEEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
